// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-gated imem issue, one-cycle read latency, DEPTH-entry circular buffer to decode.
// Head reaches decode 2 cycles after its request; when count+inflight fills the queue, pc_stall holds the PC and no request is issued.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        pc_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pend_addr;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic [CW-1:0] occupancy;
  logic          can_issue;
  logic          push;
  logic          pop;

  // Credits come from registered state only, so a same-cycle pop never frees a slot.
  assign occupancy = count + CW'(inflight);
  assign can_issue = occupancy < CW'(DEPTH);

  assign imem_req   = reset & can_issue & ~flush;
  assign pc_stall   = reset & ~can_issue;
  assign imem_addr  = {fetch_addr[31:2], 2'b00};

  assign inst_valid = (count != '0);
  assign inst_out   = inst_q[head];
  assign pc_out     = pc_q[head];

  assign push = inflight & ~flush;
  assign pop  = inst_valid & inst_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      pend_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pend_addr <= fetch_addr;
      end
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) begin
          inst_q[tail] <= imem_rdata;
          pc_q[tail]   <= pend_addr;
          tail         <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
        end
        if (pop) begin
          head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed phases plus randomized traffic, checked against a queue-based model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        pc_stall;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .pc_stall   (pc_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word contents derived from the word address, one-cycle read.
  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    return (waddr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  logic [31:0] mem_addr = 32'h0;
  always @(posedge clk) begin
    if (imem_req) mem_addr <= imem_addr;
  end
  assign imem_rdata = mem_word(mem_addr);

  int checks = 0;
  int errors = 0;

  // Reference model: list of {pc, word} entries plus one outstanding request.
  logic [63:0] q[$];
  bit          pend = 0;
  logic [31:0] pend_pc = 0;
  logic [31:0] pc = 0;
  bit          last_req = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare before the edge, advance the model across the edge.
  task automatic step(input logic [31:0] fa, input bit fl, input bit rdy);
    bit ci;
    bit req;
    fetch_addr = fa;
    flush      = fl;
    inst_ready = rdy;
    #3;
    ci  = (q.size() + int'(pend)) < DEPTH;
    req = ci && !fl;
    check("imem_req", {31'b0, imem_req}, {31'b0, req});
    check("pc_stall", {31'b0, pc_stall}, {31'b0, !ci});
    check("imem_addr", imem_addr, fa & 32'hFFFF_FFFC);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      check("pc_out", pc_out, q[0][63:32]);
      check("inst_out", inst_out, q[0][31:0]);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
      pend = 0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (pend) q.push_back({pend_pc, mem_word(pend_pc & 32'hFFFF_FFFC)});
      pend = req;
      if (req) pend_pc = fa;
    end
    last_req = req;
    #1;
  endtask

  // Next sequential PC: advance only when the fetch was accepted.
  task automatic run(input int n, input int rdy_mode);
    bit r;
    for (int i = 0; i < n; i++) begin
      r = (rdy_mode == 2) ? bit'(i % 2) : bit'(rdy_mode);
      step(pc, 1'b0, r);
      if (last_req) pc = pc + 4;
    end
  endtask

  initial begin
    reset      = 1'b0;
    fetch_addr = 32'h0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    #3;
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_pc_stall", {31'b0, pc_stall}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Streaming with decode always ready.
    pc = 0;
    run(12, 1);

    // Backpressure: fill to DEPTH, stall, then drain in order.
    step(32'h200, 1'b1, 1'b0);
    pc = 0;
    run(8, 0);
    run(8, 1);

    // Flush while count=3 and a fetch is in flight, then branch to 0x100.
    step(32'h300, 1'b1, 1'b0);
    pc = 0;
    run(4, 0);
    step(pc, 1'b1, 1'b0);
    pc = 32'h100;
    run(6, 1);

    // Wrap-around with decode toggling every cycle.
    run(24, 2);

    // Async reset mid-stream with two queued entries.
    step(32'h400, 1'b1, 1'b0);
    pc = 32'h500;
    run(3, 0);
    reset = 1'b0;
    #2;
    check("arst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("arst_pc_out", pc_out, 32'h0);
    check("arst_inst_out", inst_out, 32'h0);
    check("arst_imem_req", {31'b0, imem_req}, 32'h0);
    q.delete();
    pend = 0;
    pend_pc = 0;
    reset = 1'b1;
    run(8, 1);

    // Misaligned fetch address.
    step(32'h600, 1'b1, 1'b1);
    fetch_addr = 32'h13;
    #1;
    check("misaligned_imem_addr", imem_addr, 32'h10);
    pc = 32'h13;
    run(6, 1);

    // Randomized traffic with occasional branches.
    for (int i = 0; i < 400; i++) begin
      bit fl;
      bit rdy;
      logic [31:0] tgt;
      fl  = ($urandom_range(0, 15) == 0);
      rdy = bit'($urandom_range(0, 1));
      tgt = $urandom() & 32'h0000_FFFF;
      step(pc, fl, rdy);
      if (fl) pc = tgt;
      else if (last_req) pc = pc + 4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
